id_ex_stage: RTL and testbench

//  ID->EX pipeline register feeding the ALU. Selects in0/in1 per decoded operand selects and

---
 rtl/core_types_pkg.sv | 31 +++
 rtl/operand_fwd.sv | 34 +++
 rtl/id_ex_stage.sv | 138 +++++++++++++
 tb/tb_id_ex_stage.sv | 302 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/core_types_pkg.sv
// Shared core types: ALU opcodes, operand selects and architectural widths.
package core_types_pkg;

  localparam int unsigned N_BITS     = 32;
  localparam int unsigned REG_ADDR_W = 5;

  typedef enum logic [3:0] {
    ALU_OP_ADD,
    ALU_OP_SUB,
    ALU_OP_SLL,
    ALU_OP_SLT,
    ALU_OP_SLTU,
    ALU_OP_XOR,
    ALU_OP_SRL,
    ALU_OP_SRA,
    ALU_OP_OR,
    ALU_OP_AND
  } alu_op_t;

  typedef enum logic [1:0] {
    OPA_RS1,
    OPA_PC,
    OPA_ZERO
  } op_a_sel_t;

  typedef enum logic {
    OPB_RS2,
    OPB_IMM
  } op_b_sel_t;

endpackage

// File: rtl/operand_fwd.sv
// Three-source priority bypass for one register source: EX > MEM > WB > regfile.
// x0 always reads as zero, whatever any stage claims to write to it.
module operand_fwd #(
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic [REG_ADDR_W-1:0] src_addr,
  input  logic [DATA_W-1:0]     rf_data,
  input  logic                  ex_fwd_en,
  input  logic [REG_ADDR_W-1:0] ex_rd_addr,
  input  logic [DATA_W-1:0]     ex_data,
  input  logic                  mem_rd_we,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic [DATA_W-1:0]     mem_rd_data,
  input  logic                  wb_rd_we,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic [DATA_W-1:0]     wb_rd_data,
  output logic [DATA_W-1:0]     fwd_data
);

  always_comb begin
    fwd_data = rf_data;
    if (src_addr == '0) begin
      fwd_data = '0;
    end else if (ex_fwd_en && (ex_rd_addr == src_addr)) begin
      fwd_data = ex_data;
    end else if (mem_rd_we && (mem_rd_addr == src_addr)) begin
      fwd_data = mem_rd_data;
    end else if (wb_rd_we && (wb_rd_addr == src_addr)) begin
      fwd_data = wb_rd_data;
    end
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register: operand selection with bypass, load-use stall and
// bubble injection, registered ALU operands.
module id_ex_stage
  import core_types_pkg::*;
#(
  parameter int unsigned DATA_W     = N_BITS,
  parameter int unsigned REG_ADDR_W = core_types_pkg::REG_ADDR_W
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  id_valid,
  input  alu_op_t               id_alu_op,
  input  op_a_sel_t             id_in0_sel,
  input  op_b_sel_t             id_in1_sel,
  input  logic [REG_ADDR_W-1:0] id_rs1_addr,
  input  logic [REG_ADDR_W-1:0] id_rs2_addr,
  input  logic [DATA_W-1:0]     id_rs1_data,
  input  logic [DATA_W-1:0]     id_rs2_data,
  input  logic [DATA_W-1:0]     id_pc,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [REG_ADDR_W-1:0] id_rd_addr,
  input  logic                  id_rd_we,
  input  logic                  id_is_load,
  input  logic [DATA_W-1:0]     ex_alu_out,
  input  logic [REG_ADDR_W-1:0] mem_rd_addr,
  input  logic                  mem_rd_we,
  input  logic [DATA_W-1:0]     mem_rd_data,
  input  logic [REG_ADDR_W-1:0] wb_rd_addr,
  input  logic                  wb_rd_we,
  input  logic [DATA_W-1:0]     wb_rd_data,
  input  logic                  ex_hold,
  input  logic                  flush,
  output logic                  id_ready,
  output logic                  ex_valid,
  output alu_op_t               ex_alu_op,
  output logic [DATA_W-1:0]     ex_in0,
  output logic [DATA_W-1:0]     ex_in1,
  output logic [DATA_W-1:0]     ex_store_data,
  output logic [REG_ADDR_W-1:0] ex_rd_addr,
  output logic                  ex_rd_we,
  output logic                  ex_is_load
);

  logic              ex_fwd_en;
  logic [DATA_W-1:0] rs1_fwd;
  logic [DATA_W-1:0] rs2_fwd;
  logic [DATA_W-1:0] in0_next;
  logic [DATA_W-1:0] in1_next;
  logic              rs1_used;
  logic              rs2_used;
  logic              load_use;

  // A load in EX has no result yet, so it must not bypass from ex_alu_out.
  assign ex_fwd_en = ex_valid & ex_rd_we & ~ex_is_load;

  operand_fwd #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs1 (
    .src_addr    (id_rs1_addr),
    .rf_data     (id_rs1_data),
    .ex_fwd_en   (ex_fwd_en),
    .ex_rd_addr  (ex_rd_addr),
    .ex_data     (ex_alu_out),
    .mem_rd_we   (mem_rd_we),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .wb_rd_we    (wb_rd_we),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_data  (wb_rd_data),
    .fwd_data    (rs1_fwd)
  );

  operand_fwd #(
    .DATA_W     (DATA_W),
    .REG_ADDR_W (REG_ADDR_W)
  ) u_fwd_rs2 (
    .src_addr    (id_rs2_addr),
    .rf_data     (id_rs2_data),
    .ex_fwd_en   (ex_fwd_en),
    .ex_rd_addr  (ex_rd_addr),
    .ex_data     (ex_alu_out),
    .mem_rd_we   (mem_rd_we),
    .mem_rd_addr (mem_rd_addr),
    .mem_rd_data (mem_rd_data),
    .wb_rd_we    (wb_rd_we),
    .wb_rd_addr  (wb_rd_addr),
    .wb_rd_data  (wb_rd_data),
    .fwd_data    (rs2_fwd)
  );

  // Stores (no rd write) always consume rs2 as store data.
  assign rs1_used = (id_in0_sel == OPA_RS1);
  assign rs2_used = (id_in1_sel == OPB_RS2) | ~id_rd_we;

  assign load_use = ex_valid & ex_is_load & ex_rd_we & (ex_rd_addr != '0) & id_valid &
                    (((ex_rd_addr == id_rs1_addr) & rs1_used) |
                     ((ex_rd_addr == id_rs2_addr) & rs2_used));

  assign id_ready = ~ex_hold & ~load_use;

  always_comb begin
    unique case (id_in0_sel)
      OPA_RS1: in0_next = rs1_fwd;
      OPA_PC:  in0_next = id_pc;
      default: in0_next = '0;
    endcase
    in1_next = (id_in1_sel == OPB_IMM) ? id_imm : rs2_fwd;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ex_valid      <= 1'b0;
      ex_alu_op     <= ALU_OP_ADD;
      ex_in0        <= '0;
      ex_in1        <= '0;
      ex_store_data <= '0;
      ex_rd_addr    <= '0;
      ex_rd_we      <= 1'b0;
      ex_is_load    <= 1'b0;
    end else if (flush || (!ex_hold && load_use)) begin
      // Bubble: clearing we/is_load keeps it from forwarding or stalling.
      ex_valid   <= 1'b0;
      ex_rd_we   <= 1'b0;
      ex_is_load <= 1'b0;
    end else if (!ex_hold) begin
      ex_valid      <= id_valid;
      ex_alu_op     <= id_alu_op;
      ex_in0        <= in0_next;
      ex_in1        <= in1_next;
      ex_store_data <= rs2_fwd;
      ex_rd_addr    <= id_rd_addr;
      ex_rd_we      <= id_valid & id_rd_we;
      ex_is_load    <= id_valid & id_is_load;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: one task per scenario, hand-computed expectations.
module tb_id_ex_stage;
  import core_types_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        id_valid;
  alu_op_t     id_alu_op;
  op_a_sel_t   id_in0_sel;
  op_b_sel_t   id_in1_sel;
  logic [4:0]  id_rs1_addr, id_rs2_addr, id_rd_addr;
  logic [31:0] id_rs1_data, id_rs2_data, id_pc, id_imm;
  logic        id_rd_we, id_is_load;
  logic [31:0] ex_alu_out;
  logic [4:0]  mem_rd_addr, wb_rd_addr;
  logic        mem_rd_we, wb_rd_we;
  logic [31:0] mem_rd_data, wb_rd_data;
  logic        ex_hold, flush;
  logic        id_ready, ex_valid;
  alu_op_t     ex_alu_op;
  logic [31:0] ex_in0, ex_in1, ex_store_data;
  logic [4:0]  ex_rd_addr;
  logic        ex_rd_we, ex_is_load;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  id_ex_stage dut (
    .clk           (clk),
    .rst           (rst),
    .id_valid      (id_valid),
    .id_alu_op     (id_alu_op),
    .id_in0_sel    (id_in0_sel),
    .id_in1_sel    (id_in1_sel),
    .id_rs1_addr   (id_rs1_addr),
    .id_rs2_addr   (id_rs2_addr),
    .id_rs1_data   (id_rs1_data),
    .id_rs2_data   (id_rs2_data),
    .id_pc         (id_pc),
    .id_imm        (id_imm),
    .id_rd_addr    (id_rd_addr),
    .id_rd_we      (id_rd_we),
    .id_is_load    (id_is_load),
    .ex_alu_out    (ex_alu_out),
    .mem_rd_addr   (mem_rd_addr),
    .mem_rd_we     (mem_rd_we),
    .mem_rd_data   (mem_rd_data),
    .wb_rd_addr    (wb_rd_addr),
    .wb_rd_we      (wb_rd_we),
    .wb_rd_data    (wb_rd_data),
    .ex_hold       (ex_hold),
    .flush         (flush),
    .id_ready      (id_ready),
    .ex_valid      (ex_valid),
    .ex_alu_op     (ex_alu_op),
    .ex_in0        (ex_in0),
    .ex_in1        (ex_in1),
    .ex_store_data (ex_store_data),
    .ex_rd_addr    (ex_rd_addr),
    .ex_rd_we      (ex_rd_we),
    .ex_is_load    (ex_is_load)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    id_valid = 0; id_alu_op = ALU_OP_ADD; id_in0_sel = OPA_RS1; id_in1_sel = OPB_RS2;
    id_rs1_addr = 0; id_rs2_addr = 0; id_rs1_data = 0; id_rs2_data = 0;
    id_pc = 0; id_imm = 0; id_rd_addr = 0; id_rd_we = 0; id_is_load = 0;
    ex_alu_out = 0; mem_rd_addr = 0; mem_rd_we = 0; mem_rd_data = 0;
    wb_rd_addr = 0; wb_rd_we = 0; wb_rd_data = 0; ex_hold = 0; flush = 0;
  endtask

  // Idle inputs and clock one bubble through so EX starts empty.
  task automatic clear_ex();
    idle_inputs();
    step();
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    step();
    step();
    checks++; if (ex_valid !== 1'b0) begin errors++;
      $display("FAIL reset ex_valid: got %b want 0", ex_valid); end
    checks++; if (ex_alu_op !== ALU_OP_ADD) begin errors++;
      $display("FAIL reset ex_alu_op: got %0d want %0d", ex_alu_op, ALU_OP_ADD); end
    checks++; if ({ex_in0, ex_in1, ex_store_data} !== 96'h0) begin errors++;
      $display("FAIL reset data: got %h %h %h want 0", ex_in0, ex_in1, ex_store_data); end
    checks++; if ({ex_rd_addr, ex_rd_we, ex_is_load} !== 7'h0) begin errors++;
      $display("FAIL reset rd: got %h %b %b want 0", ex_rd_addr, ex_rd_we, ex_is_load); end
    checks++; if (id_ready !== 1'b1) begin errors++;
      $display("FAIL reset id_ready: got %b want 1", id_ready); end
    rst = 0;
  endtask

  task automatic test_basic_add();
    idle_inputs();
    id_valid = 1; id_alu_op = ALU_OP_ADD; id_rs1_addr = 1; id_rs2_addr = 2;
    id_rs1_data = 5; id_rs2_data = 7; id_rd_addr = 3; id_rd_we = 1;
    step();
    checks++; if (ex_valid !== 1'b1) begin errors++;
      $display("FAIL add ex_valid: got %b want 1", ex_valid); end
    checks++; if (ex_in0 !== 32'd5) begin errors++;
      $display("FAIL add ex_in0: got %h want 5", ex_in0); end
    checks++; if (ex_in1 !== 32'd7) begin errors++;
      $display("FAIL add ex_in1: got %h want 7", ex_in1); end
    checks++; if (ex_alu_op !== ALU_OP_ADD) begin errors++;
      $display("FAIL add ex_alu_op: got %0d want %0d", ex_alu_op, ALU_OP_ADD); end
    checks++; if (ex_store_data !== 32'd7) begin errors++;
      $display("FAIL add store_data: got %h want 7", ex_store_data); end
    checks++; if (ex_rd_addr !== 5'd3 || ex_rd_we !== 1'b1) begin errors++;
      $display("FAIL add rd: got %0d/%b want 3/1", ex_rd_addr, ex_rd_we); end
  endtask

  task automatic test_fwd_priority();
    clear_ex();
    id_valid = 1; id_rd_addr = 1; id_rd_we = 1;
    step();
    ex_alu_out = 32'h10;
    mem_rd_addr = 1; mem_rd_we = 1; mem_rd_data = 32'h20;
    wb_rd_addr = 1; wb_rd_we = 1; wb_rd_data = 32'h30;
    id_alu_op = ALU_OP_OR; id_rs1_addr = 1; id_rs1_data = 32'h99;
    id_in1_sel = OPB_IMM; id_imm = 32'h44; id_rd_addr = 5;
    step();
    checks++; if (ex_in0 !== 32'h10) begin errors++;
      $display("FAIL fwd_ex in0: got %h want 10", ex_in0); end
    checks++; if (ex_in1 !== 32'h44 || ex_alu_op !== ALU_OP_OR) begin errors++;
      $display("FAIL fwd_ex imm/op: got %h/%0d want 44/%0d", ex_in1, ex_alu_op, ALU_OP_OR); end
    ex_alu_out = 32'h50;
    step();
    checks++; if (ex_in0 !== 32'h20) begin errors++;
      $display("FAIL fwd_mem in0: got %h want 20", ex_in0); end
    mem_rd_we = 0;
    step();
    checks++; if (ex_in0 !== 32'h30) begin errors++;
      $display("FAIL fwd_wb in0: got %h want 30", ex_in0); end
    wb_rd_we = 0;
    step();
    checks++; if (ex_in0 !== 32'h99) begin errors++;
      $display("FAIL fwd_rf in0: got %h want 99", ex_in0); end
    id_in0_sel = OPA_PC; id_pc = 32'h1000;
    step();
    checks++; if (ex_in0 !== 32'h1000) begin errors++;
      $display("FAIL sel_pc in0: got %h want 1000", ex_in0); end
    id_in0_sel = OPA_ZERO;
    step();
    checks++; if (ex_in0 !== 32'h0) begin errors++;
      $display("FAIL sel_zero in0: got %h want 0", ex_in0); end
  endtask

  task automatic test_load_use();
    clear_ex();
    id_valid = 1; id_rd_addr = 4; id_rd_we = 1; id_is_load = 1;
    step();
    id_is_load = 0; id_rd_addr = 9; id_rs2_addr = 4; id_rs2_data = 32'h5555;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++;
      $display("FAIL lu_rs2 id_ready: got %b want 0", id_ready); end
    id_in1_sel = OPB_IMM;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++;
      $display("FAIL lu_imm id_ready: got %b want 1", id_ready); end
    id_rd_we = 0;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++;
      $display("FAIL lu_store id_ready: got %b want 0", id_ready); end
    id_rd_we = 1; id_in1_sel = OPB_RS2;
    step();
    checks++; if (ex_valid !== 1'b0 || ex_rd_we !== 1'b0 || ex_is_load !== 1'b0) begin errors++;
      $display("FAIL lu_bubble: got v=%b we=%b ld=%b want 0 0 0", ex_valid, ex_rd_we, ex_is_load);
    end
    mem_rd_addr = 4; mem_rd_we = 1; mem_rd_data = 32'hDEAD;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++;
      $display("FAIL lu_release id_ready: got %b want 1", id_ready); end
    step();
    checks++; if (ex_valid !== 1'b1 || ex_in1 !== 32'hDEAD) begin errors++;
      $display("FAIL lu_memfwd: got v=%b in1=%h want 1/dead", ex_valid, ex_in1); end
    checks++; if (ex_store_data !== 32'hDEAD) begin errors++;
      $display("FAIL lu_store_data: got %h want dead", ex_store_data); end
  endtask

  task automatic test_x0();
    clear_ex();
    id_valid = 1; id_rd_addr = 0; id_rd_we = 1; id_is_load = 1;
    step();
    id_is_load = 0; id_rd_addr = 2;
    ex_alu_out = 32'hFFFF_FFFF;
    mem_rd_addr = 0; mem_rd_we = 1; mem_rd_data = 32'hFFFF_FFFF;
    wb_rd_addr = 0; wb_rd_we = 1; wb_rd_data = 32'hFFFF_FFFF;
    id_rs1_data = 32'hFFFF_FFFF; id_rs2_data = 32'hFFFF_FFFF;
    #1;
    checks++; if (id_ready !== 1'b1) begin errors++;
      $display("FAIL x0 id_ready: got %b want 1", id_ready); end
    step();
    checks++; if (ex_in0 !== 32'h0 || ex_in1 !== 32'h0) begin errors++;
      $display("FAIL x0 operands: got %h %h want 0 0", ex_in0, ex_in1); end
  endtask

  task automatic test_hold_flush();
    clear_ex();
    id_valid = 1; id_alu_op = ALU_OP_SUB; id_rs1_addr = 7; id_rs2_addr = 8;
    id_rs1_data = 32'h11; id_rs2_data = 32'h22; id_rd_addr = 6; id_rd_we = 1;
    step();
    ex_hold = 1; id_alu_op = ALU_OP_XOR; id_rs1_data = 32'h33; id_rs2_data = 32'h44;
    id_rd_addr = 7;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++;
      $display("FAIL hold id_ready: got %b want 0", id_ready); end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (ex_valid !== 1'b1 || ex_alu_op !== ALU_OP_SUB || ex_in0 !== 32'h11 ||
          ex_in1 !== 32'h22 || ex_rd_addr !== 5'd6) begin
        errors++;
        $display("FAIL hold cycle%0d: got v=%b op=%0d %h %h rd=%0d want 1 %0d 11 22 6",
                 i, ex_valid, ex_alu_op, ex_in0, ex_in1, ex_rd_addr, ALU_OP_SUB);
      end
    end
    flush = 1;
    step();
    checks++; if (ex_valid !== 1'b0 || ex_rd_we !== 1'b0) begin errors++;
      $display("FAIL flush_hold: got v=%b we=%b want 0 0", ex_valid, ex_rd_we); end
    flush = 0; ex_hold = 0;
  endtask

  task automatic test_reset_in_stall();
    clear_ex();
    id_valid = 1; id_alu_op = ALU_OP_AND; id_rd_addr = 4; id_rd_we = 1; id_is_load = 1;
    id_rs1_data = 32'h77; id_rs2_data = 32'h88;
    step();
    id_is_load = 0; id_rs1_addr = 4; id_rd_addr = 10;
    #1;
    checks++; if (id_ready !== 1'b0) begin errors++;
      $display("FAIL rst_stall pre id_ready: got %b want 0", id_ready); end
    rst = 1;
    step();
    checks++; if (ex_valid !== 1'b0 || ex_alu_op !== ALU_OP_ADD) begin errors++;
      $display("FAIL rst_stall valid/op: got %b/%0d want 0/%0d", ex_valid, ex_alu_op, ALU_OP_ADD);
    end
    checks++;
    if ({ex_in0, ex_in1, ex_store_data} !== 96'h0 ||
        {ex_rd_addr, ex_rd_we, ex_is_load} !== 7'h0) begin
      errors++;
      $display("FAIL rst_stall regs: got %h %h %h %0d %b %b want zeros",
               ex_in0, ex_in1, ex_store_data, ex_rd_addr, ex_rd_we, ex_is_load);
    end
    checks++; if (id_ready !== 1'b1) begin errors++;
      $display("FAIL rst_stall id_ready: got %b want 1", id_ready); end
    rst = 0;
  endtask

  // Dependent chain: each instruction reads the previous one's rd straight from EX.
  task automatic test_back_to_back();
    alu_op_t ops[6];
    logic [31:0] exp_in0;
    ops = '{ALU_OP_ADD, ALU_OP_SUB, ALU_OP_XOR, ALU_OP_SLL, ALU_OP_SRA, ALU_OP_SLTU};
    clear_ex();
    id_valid = 1; id_rd_we = 1; id_in1_sel = OPB_IMM;
    for (int i = 0; i < 6; i++) begin
      id_alu_op   = ops[i];
      id_rs1_addr = (i == 0) ? 5'd10 : 5'(i);
      id_rs1_data = 32'h100 + 32'(i);
      id_imm      = 32'(i) * 4;
      id_rd_addr  = 5'(i + 1);
      ex_alu_out  = 32'hA000 + 32'(i);
      exp_in0     = (i == 0) ? 32'h100 : 32'hA000 + 32'(i);
      step();
      checks++;
      if (ex_alu_op !== ops[i] || ex_in0 !== exp_in0 || ex_in1 !== 32'(i) * 4 ||
          ex_rd_addr !== 5'(i + 1) || ex_valid !== 1'b1) begin
        errors++;
        $display("FAIL b2b[%0d]: got op=%0d in0=%h in1=%h rd=%0d v=%b want op=%0d in0=%h in1=%h rd=%0d",
                 i, ex_alu_op, ex_in0, ex_in1, ex_rd_addr, ex_valid, ops[i], exp_in0,
                 32'(i) * 4, i + 1);
      end
    end
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    test_reset();
    test_basic_add();
    test_fwd_priority();
    test_load_use();
    test_x0();
    test_hold_flush();
    test_reset_in_stall();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
